// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status from ID/EX/MEM/WB in, stage enables, flushes and status out.
// The controller uses the slave modport; the pipeline datapath uses the master modport.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_halt;
  logic [4:0]       ex_rd;
  logic             ex_rf_wen;
  logic             ex_is_load;
  logic             ex_redirect;
  logic [4:0]       mem_rd;
  logic             mem_rf_wen;
  logic [4:0]       wb_rd;
  logic             wb_rf_wen;
  logic             mem_busy;

  logic             pc_wen;
  logic             pc_sel;
  logic             if_id_wen;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             pipe_freeze;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
           ex_rd, ex_rf_wen, ex_is_load, ex_redirect,
           mem_rd, mem_rf_wen, wb_rd, wb_rf_wen, mem_busy,
    input  pc_wen, pc_sel, if_id_wen, if_id_flush, id_ex_flush, pipe_freeze,
           fwd_a, fwd_b, halted, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
           ex_rd, ex_rf_wen, ex_is_load, ex_redirect,
           mem_rd, mem_rf_wen, wb_rd, wb_rf_wen, mem_busy,
    output pc_wen, pc_sel, if_id_wen, if_id_flush, id_ex_flush, pipe_freeze,
           fwd_a, fwd_b, halted, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: forwarding selects, load-use stall, redirect flush, mem-busy freeze, ebreak drain.
// Outputs are combinational from state and inputs; state and counters update on posedge clk.
module pipe_hazard_ctrl #(
  parameter int CNT_W     = 32,
  parameter int TIMEOUT   = 255,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int BW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {S_RUN, S_LSTALL, S_MWAIT, S_DRAIN, S_HALT} state_t;

  state_t           r_state, w_state_nxt;
  logic [DW-1:0]    r_drain_cnt, w_drain_nxt;
  logic [BW-1:0]    r_busy_cnt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic             w_pc_wen, w_pc_sel, w_if_id_wen, w_if_id_flush, w_id_ex_flush, w_pipe_freeze;
  logic [1:0]       w_fwd_a, w_fwd_b, w_fwd_a_raw, w_fwd_b_raw;
  logic             w_lu, w_redirect_taken;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs, input logic use_rs,
    input logic [4:0] ex_rd, input logic ex_wen,
    input logic [4:0] mem_rd, input logic mem_wen,
    input logic [4:0] wb_rd, input logic wb_wen
  );
    // x0 is hardwired zero, so a write to it never produces forwardable data
    if (!use_rs || rs == 5'd0) return 2'd0;
    if (ex_wen && ex_rd == rs)   return 2'd1;
    if (mem_wen && mem_rd == rs) return 2'd2;
    if (wb_wen && wb_rd == rs)   return 2'd3;
    return 2'd0;
  endfunction

  assign w_fwd_a_raw = fwd_sel(bus.id_rs1, bus.id_use_rs1, bus.ex_rd, bus.ex_rf_wen,
                               bus.mem_rd, bus.mem_rf_wen, bus.wb_rd, bus.wb_rf_wen);
  assign w_fwd_b_raw = fwd_sel(bus.id_rs2, bus.id_use_rs2, bus.ex_rd, bus.ex_rf_wen,
                               bus.mem_rd, bus.mem_rf_wen, bus.wb_rd, bus.wb_rf_wen);

  assign w_lu = bus.ex_is_load && bus.ex_rf_wen && (bus.ex_rd != 5'd0) && bus.id_valid &&
                ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                 (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));

  always_comb begin
    w_pc_wen         = 1'b0;
    w_pc_sel         = 1'b0;
    w_if_id_wen      = 1'b0;
    w_if_id_flush    = 1'b0;
    w_id_ex_flush    = 1'b0;
    w_pipe_freeze    = 1'b0;
    w_fwd_a          = w_fwd_a_raw;
    w_fwd_b          = w_fwd_b_raw;
    w_state_nxt      = r_state;
    w_drain_nxt      = r_drain_cnt;
    w_redirect_taken = 1'b0;
    if (!rst) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      w_fwd_a       = 2'd0;
      w_fwd_b       = 2'd0;
      w_state_nxt   = S_RUN;
    end else begin
      case (r_state)
        // MWAIT with mem_busy low re-evaluates the run list so a held redirect is taken immediately
        S_RUN, S_LSTALL, S_MWAIT: begin
          if (bus.mem_busy) begin
            w_pipe_freeze = 1'b1;
            w_state_nxt   = S_MWAIT;
          end else if (bus.ex_redirect) begin
            w_pc_wen         = 1'b1;
            w_pc_sel         = 1'b1;
            w_if_id_flush    = 1'b1;
            w_id_ex_flush    = 1'b1;
            w_redirect_taken = 1'b1;
            w_state_nxt      = S_RUN;
          end else if (w_lu) begin
            w_id_ex_flush = 1'b1;
            w_state_nxt   = S_LSTALL;
          end else if (bus.id_halt && bus.id_valid) begin
            w_id_ex_flush = 1'b1;
            w_drain_nxt   = DW'(DRAIN_CYC);
            w_state_nxt   = S_DRAIN;
          end else begin
            w_pc_wen    = 1'b1;
            w_if_id_wen = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
        S_DRAIN: begin
          w_id_ex_flush = 1'b1;
          if (bus.mem_busy) begin
            w_pipe_freeze = 1'b1;
          end else if (r_drain_cnt == DW'(1)) begin
            w_state_nxt = S_HALT;
          end else begin
            w_drain_nxt = r_drain_cnt - 1'b1;
          end
        end
        S_HALT: begin
          w_id_ex_flush = 1'b1;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_RUN;
      r_drain_cnt   <= '0;
      r_busy_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (!bus.mem_busy)
        r_busy_cnt <= '0;
      else if (r_busy_cnt != BW'(TIMEOUT - 1))
        r_busy_cnt <= r_busy_cnt + 1'b1;
      if (bus.mem_busy && r_busy_cnt == BW'(TIMEOUT - 1))
        r_mem_timeout <= 1'b1;
      if (!w_pc_wen && r_state != S_HALT && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_redirect_taken && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.pc_wen      = w_pc_wen;
  assign bus.pc_sel      = w_pc_sel;
  assign bus.if_id_wen   = w_if_id_wen;
  assign bus.if_id_flush = w_if_id_flush;
  assign bus.id_ex_flush = w_id_ex_flush;
  assign bus.pipe_freeze = w_pipe_freeze;
  assign bus.fwd_a       = w_fwd_a;
  assign bus.fwd_b       = w_fwd_b;
  assign bus.halted      = (r_state == S_HALT);
  assign bus.mem_timeout = r_mem_timeout;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with small counters (CNT_W=4), TIMEOUT=8, DRAIN_CYC=3.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  pipe_hazard_ctrl_if #(.CNT_W(4)) bus ();

  pipe_hazard_ctrl #(.CNT_W(4), .TIMEOUT(8), .DRAIN_CYC(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.id_halt = 0; bus.ex_rd = 0; bus.ex_rf_wen = 0; bus.ex_is_load = 0; bus.ex_redirect = 0;
    bus.mem_rd = 0; bus.mem_rf_wen = 0; bus.wb_rd = 0; bus.wb_rf_wen = 0; bus.mem_busy = 0;
  endtask

  task automatic set_lu();
    idle();
    bus.ex_is_load = 1; bus.ex_rf_wen = 1; bus.ex_rd = 5;
    bus.id_valid = 1; bus.id_rs1 = 5; bus.id_use_rs1 = 1; bus.id_rs2 = 1; bus.id_use_rs2 = 1;
  endtask

  initial begin
    // reset: outputs forced, forwarding suppressed even with a matching source
    rst = 0;
    idle();
    bus.ex_rd = 7; bus.ex_rf_wen = 1; bus.id_rs1 = 7; bus.id_use_rs1 = 1;
    tick(); tick();
    check("rst_pc_wen", bus.pc_wen, 0);
    check("rst_if_id_wen", bus.if_id_wen, 0);
    check("rst_if_id_flush", bus.if_id_flush, 1);
    check("rst_id_ex_flush", bus.id_ex_flush, 1);
    check("rst_freeze", bus.pipe_freeze, 0);
    check("rst_fwd_a", bus.fwd_a, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_timeout", bus.mem_timeout, 0);
    check("rst_stall_cnt", bus.stall_cnt, 0);
    check("rst_flush_cnt", bus.flush_cnt, 0);
    rst = 1;
    idle();
    #1;
    check("run_pc_wen", bus.pc_wen, 1);
    check("run_if_id_wen", bus.if_id_wen, 1);
    check("run_if_id_flush", bus.if_id_flush, 0);

    // forwarding priority within one cycle
    bus.ex_rd = 7; bus.mem_rd = 7; bus.wb_rd = 7;
    bus.ex_rf_wen = 1; bus.mem_rf_wen = 1; bus.wb_rf_wen = 1;
    bus.id_rs1 = 7; bus.id_use_rs1 = 1; bus.id_rs2 = 7; bus.id_use_rs2 = 0;
    #1;
    check("fwd_a_ex", bus.fwd_a, 1);
    check("fwd_b_unused", bus.fwd_b, 0);
    bus.ex_rf_wen = 0;
    #1;
    check("fwd_a_mem", bus.fwd_a, 2);
    bus.mem_rf_wen = 0;
    #1;
    check("fwd_a_wb", bus.fwd_a, 3);
    bus.ex_rd = 0; bus.mem_rd = 0; bus.wb_rd = 0; bus.id_rs1 = 0;
    bus.ex_rf_wen = 1; bus.mem_rf_wen = 1;
    #1;
    check("fwd_a_x0", bus.fwd_a, 0);
    bus.ex_rd = 3; bus.mem_rd = 9; bus.wb_rd = 9; bus.id_rs2 = 9; bus.id_use_rs2 = 1;
    #1;
    check("fwd_b_mem", bus.fwd_b, 2);
    idle();
    tick();

    // load-use: one stall cycle, then MEM forwarding
    set_lu();
    #1;
    check("lu_pc_wen", bus.pc_wen, 0);
    check("lu_if_id_wen", bus.if_id_wen, 0);
    check("lu_id_ex_flush", bus.id_ex_flush, 1);
    tick();
    check("lu_stall_cnt", bus.stall_cnt, 1);
    bus.ex_is_load = 0; bus.ex_rf_wen = 0; bus.ex_rd = 0;
    bus.mem_rd = 5; bus.mem_rf_wen = 1;
    #1;
    check("lstall_fwd_a", bus.fwd_a, 2);
    check("lstall_pc_wen", bus.pc_wen, 1);
    tick();
    check("lstall_stall_cnt", bus.stall_cnt, 1);

    // redirect beats load-use and ebreak
    set_lu();
    bus.id_halt = 1; bus.ex_redirect = 1;
    #1;
    check("redir_pc_sel", bus.pc_sel, 1);
    check("redir_pc_wen", bus.pc_wen, 1);
    check("redir_if_id_flush", bus.if_id_flush, 1);
    check("redir_id_ex_flush", bus.id_ex_flush, 1);
    tick();
    idle();
    #1;
    check("redir_flush_cnt", bus.flush_cnt, 1);
    check("redir_next_run", bus.if_id_wen, 1);
    check("redir_next_pc_sel", bus.pc_sel, 0);

    // mem_busy for 4 cycles holding a redirect
    bus.ex_redirect = 1; bus.mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mw_freeze", bus.pipe_freeze, 1);
      check("mw_pc_wen", bus.pc_wen, 0);
      check("mw_no_flush", bus.if_id_flush, 0);
      tick();
    end
    bus.mem_busy = 0;
    #1;
    check("mw_redir_pc_wen", bus.pc_wen, 1);
    check("mw_redir_pc_sel", bus.pc_sel, 1);
    check("mw_unfrozen", bus.pipe_freeze, 0);
    check("mw_stall_cnt", bus.stall_cnt, 5);
    tick();
    idle();
    check("mw_flush_cnt", bus.flush_cnt, 2);
    check("mw_no_timeout", bus.mem_timeout, 0);

    // ebreak drain: 3 drain cycles plus 2 busy cycles, redirect ignored
    bus.id_valid = 1; bus.id_halt = 1;
    #1;
    check("halt_pc_wen", bus.pc_wen, 0);
    check("halt_id_ex_flush", bus.id_ex_flush, 1);
    check("halt_if_id_wen", bus.if_id_wen, 0);
    tick();
    idle();
    bus.ex_redirect = 1;
    #1;
    check("drain_ign_pc_sel", bus.pc_sel, 0);
    check("drain_ign_pc_wen", bus.pc_wen, 0);
    check("drain_halted0", bus.halted, 0);
    tick();
    bus.ex_redirect = 0; bus.mem_busy = 1;
    #1;
    check("drain_freeze", bus.pipe_freeze, 1);
    tick(); tick();
    bus.mem_busy = 0;
    #1;
    check("drain_ext_halted", bus.halted, 0);
    check("drain_unfrozen", bus.pipe_freeze, 0);
    tick();
    check("drain_last_halted", bus.halted, 0);
    tick();
    check("halted", bus.halted, 1);
    check("halted_pc_wen", bus.pc_wen, 0);
    check("halted_id_ex_flush", bus.id_ex_flush, 1);
    check("drain_stall_cnt", bus.stall_cnt, 11);
    tick(); tick();
    check("halt_hold", bus.halted, 1);
    check("halt_stall_frozen", bus.stall_cnt, 11);
    rst = 0;
    tick();
    check("rst_clr_halted", bus.halted, 0);
    check("rst_clr_stall", bus.stall_cnt, 0);
    check("rst_clr_flush", bus.flush_cnt, 0);
    rst = 1;

    // memory timeout: 7 busy cycles do not trip, 8 do
    bus.mem_busy = 1;
    repeat (7) tick();
    bus.mem_busy = 0;
    #1;
    check("to7_timeout", bus.mem_timeout, 0);
    check("to7_stall_cnt", bus.stall_cnt, 7);
    tick();
    bus.mem_busy = 1;
    repeat (7) tick();
    check("to8_before", bus.mem_timeout, 0);
    tick();
    check("to8_set", bus.mem_timeout, 1);
    bus.mem_busy = 0;
    tick();
    check("to8_sticky", bus.mem_timeout, 1);
    check("to8_stall_cnt", bus.stall_cnt, 15);

    // stall counter saturates at all-ones
    set_lu();
    repeat (3) tick();
    check("sat_pc_wen", bus.pc_wen, 0);
    check("sat_stall_cnt", bus.stall_cnt, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
